mult_unit: RTL and testbench
============================

# mult_unit

Iterative shift-and-add multiplier for `mult`/`multu`. It owns the HI/LO register pair and sits beside the ALU/shifter on the execute stage, taking the same register-file operands. It produces a 64-bit product over a fixed number of cycles and stalls the pipeline through `busy`. `mfhi`/`mflo` read HI/LO directly; `mthi`/`mtlo` write them.

## Interface
- `WIDTH`, 32, operand width; product is 2*WIDTH.
- `clk`  in  1  rising-edge clock
- `reset_n`  in  1  asynchronous, active-low reset
- `start`  in  1  begin a multiply; sampled only in IDLE
- `is_signed`  in  1  1 = `mult` (two's complement), 0 = `multu`; sampled with `start`
- `op_a`, `op_b`  in  WIDTH  multiplicand and multiplier; sampled with `start`
- `hi_we`, `lo_we`  in  1  `mthi`/`mtlo` write enables
- `wdata`  in  WIDTH  data for `mthi`/`mtlo`
- `busy`  out  1  high while a multiply is in flight
- `done`  out  1  one-cycle pulse when HI/LO hold a new product
- `hi`, `lo`  out  WIDTH  registered HI/LO contents

## Operation
- States: IDLE, CALC, SIGN.
- IDLE, `start`=1:
  - latch magnitudes: `|op_a|`, `|op_b|` if `is_signed`, else raw values;
  - set `neg = is_signed & (op_a[W-1] ^ op_b[W-1])`;
  - clear the 2W accumulator and counter; go to CALC.
- CALC, one step per cycle:
  - if multiplier bit0 = 1, add the 2W multiplicand to the accumulator;
  - shift the multiplicand left by 1 and the multiplier right by 1; count += 1;
  - after WIDTH steps, go to SIGN.
- SIGN:
  - result = `neg ? -acc : acc` (2W two's complement, wraps mod 2^(2W));
  - write `hi` = result[2W-1:W] and `lo` = result[W-1:0];
  - pulse `done`; go to IDLE.
- Magnitude of 0x80000000 is 0x80000000 read as unsigned, which is correct. `neg` with a zero product still yields 0.
- There is no early termination. Latency is fixed.
- `hi_we`/`lo_we` take effect only in IDLE, written at the clock edge.
  - When asserted with `start` in the same cycle, the write still occurs; the product overwrites it later.
  - Ignored in CALC and SIGN.
- `start` in CALC or SIGN is ignored; no queueing.
- `busy` = (state != IDLE), registered.
- Reset, asynchronous, any state: state = IDLE; `hi` = `lo` = 0; `busy` = `done` = 0; accumulator and counter cleared. An in-flight multiply is discarded.

## Timing
- Edge E0 samples `start`=1 in IDLE.
- CALC steps occur on edges E1..E32 (WIDTH=32).
- SIGN completes on E33: `hi`/`lo` update and `done`=1 for the cycle E33–E34.
- `busy` is high from E0 until E33, low in the `done` cycle.
- `start` may be reasserted in the `done` cycle; it is accepted on E34.
- General latency: `done` rises WIDTH+1 edges after the accepting edge.
- `hi`/`lo` are stable and hold the previous value throughout CALC.

## Structure
- `mult_pkg` holds:
  - the state enum (IDLE/CALC/SIGN);
  - `CNT_W` = $clog2(WIDTH)+1;
  - the 2W product width constant.
- Sub-module `mult_datapath` holds the accumulator, multiplicand/multiplier shift registers, adder and final negator. It is controlled by `load`/`step`/`fix` strobes.
- The top level holds the FSM, counter, and HI/LO registers.

## Test plan
- Unsigned max: `multu` 0xFFFFFFFF × 0xFFFFFFFF -> `hi`=0xFFFFFFFE, `lo`=0x00000001; `done` on E33; `busy` high for 33 cycles.
- Signed mixed: `mult` -3 × 7 -> `hi`=0xFFFFFFFF, `lo`=0xFFFFFFEB. Also 0x80000000 × 0x80000000 signed -> `hi`=0x40000000, `lo`=0.
- Zero and sign: `mult` 0xFFFFFFFF × 0 -> `hi`=`lo`=0. `multu` 0x80000000 × 2 -> `hi`=1, `lo`=0.
- Busy protection:
  - 2nd `start` (5×5) at cycle 10 of a 3×4 multiply -> ignored; result `lo`=12.
  - `mthi` 0xDEAD during CALC -> ignored.
  - `mthi` 0xDEAD in IDLE -> `hi`=0xDEAD next cycle.
- Reset mid-operation: assert `reset_n`=0 at cycle 15 of a multiply -> `hi`=`lo`=0 and `busy`=`done`=0 immediately. After release, 6 × 7 -> `lo`=42 with normal latency.
- Back-to-back: `start` in the `done` cycle -> second product appears exactly 33 edges later.

Source files
------------

// File: rtl/mult_pkg.sv
// rtl/mult_pkg.sv - shared types and sizing for the iterative multiplier
package mult_pkg;

  typedef enum logic [1:0] {
    IDLE,
    CALC,
    SIGN
  } mult_state_e;

  localparam int MULT_W = 32;
  localparam int PROD_W = 2 * MULT_W;
  localparam int CNT_W  = $clog2(MULT_W) + 1;

  // Counter width for an arbitrary operand width; one spare bit keeps WIDTH representable.
  function automatic int cnt_width(input int w);
    return $clog2(w) + 1;
  endfunction

endpackage

// File: rtl/mult_datapath.sv
// rtl/mult_datapath.sv - shift-and-add datapath: accumulator, shift registers, final negator
module mult_datapath
  import mult_pkg::*;
#(
  parameter int WIDTH = MULT_W
) (
  input  logic               clk,
  input  logic               reset_n,
  input  logic               load,
  input  logic               step,
  input  logic               fix,
  input  logic               is_signed,
  input  logic [WIDTH-1:0]   op_a,
  input  logic [WIDTH-1:0]   op_b,
  output logic [2*WIDTH-1:0] result
);

  logic [2*WIDTH-1:0] acc;
  logic [2*WIDTH-1:0] mcand;
  logic [WIDTH-1:0]   mplier;
  logic               neg;
  logic [WIDTH-1:0]   mag_a;
  logic [WIDTH-1:0]   mag_b;

  // The most negative value negates to itself, which read unsigned is the right magnitude.
  assign mag_a = (is_signed && op_a[WIDTH-1]) ? -op_a : op_a;
  assign mag_b = (is_signed && op_b[WIDTH-1]) ? -op_b : op_b;

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      acc    <= '0;
      mcand  <= '0;
      mplier <= '0;
      neg    <= 1'b0;
    end else if (load) begin
      acc    <= '0;
      mcand  <= {{WIDTH{1'b0}}, mag_a};
      mplier <= mag_b;
      neg    <= is_signed & (op_a[WIDTH-1] ^ op_b[WIDTH-1]);
    end else if (step) begin
      if (mplier[0]) begin
        acc <= acc + mcand;
      end
      mcand  <= mcand << 1;
      mplier <= mplier >> 1;
    end
  end

  assign result = (fix && neg) ? -acc : acc;

endmodule

// File: rtl/mult_unit.sv
// rtl/mult_unit.sv - mult/multu unit with HI/LO registers, fixed WIDTH+1 cycle latency
module mult_unit
  import mult_pkg::*;
#(
  parameter int WIDTH = MULT_W
) (
  input  logic             clk,
  input  logic             reset_n,
  input  logic             start,
  input  logic             is_signed,
  input  logic [WIDTH-1:0] op_a,
  input  logic [WIDTH-1:0] op_b,
  input  logic             hi_we,
  input  logic             lo_we,
  input  logic [WIDTH-1:0] wdata,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] hi,
  output logic [WIDTH-1:0] lo
);

  localparam int CW = cnt_width(WIDTH);

  mult_state_e        state;
  mult_state_e        state_next;
  logic [CW-1:0]      cnt;
  logic               load;
  logic               step;
  logic               fix;
  logic [2*WIDTH-1:0] result;

  mult_datapath #(.WIDTH(WIDTH)) u_datapath (
    .clk       (clk),
    .reset_n   (reset_n),
    .load      (load),
    .step      (step),
    .fix       (fix),
    .is_signed (is_signed),
    .op_a      (op_a),
    .op_b      (op_b),
    .result    (result)
  );

  always_comb begin
    state_next = state;
    load       = 1'b0;
    step       = 1'b0;
    fix        = 1'b0;
    case (state)
      IDLE: begin
        if (start) begin
          load       = 1'b1;
          state_next = CALC;
        end
      end
      CALC: begin
        step = 1'b1;
        if (cnt == CW'(WIDTH - 1)) begin
          state_next = SIGN;
        end
      end
      SIGN: begin
        fix        = 1'b1;
        state_next = IDLE;
      end
      default: state_next = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state <= IDLE;
      cnt   <= '0;
      busy  <= 1'b0;
      done  <= 1'b0;
    end else begin
      state <= state_next;
      busy  <= (state_next != IDLE);
      done  <= fix;
      if (load) begin
        cnt <= '0;
      end else if (step) begin
        cnt <= cnt + 1'b1;
      end
    end
  end

  // Software writes land only while idle; a product accepted in the same cycle overwrites them later.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      hi <= '0;
      lo <= '0;
    end else if (fix) begin
      hi <= result[2*WIDTH-1:WIDTH];
      lo <= result[WIDTH-1:0];
    end else if (state == IDLE) begin
      if (hi_we) begin
        hi <= wdata;
      end
      if (lo_we) begin
        lo <= wdata;
      end
    end
  end

endmodule

// File: tb/tb_mult_unit.sv
// tb/tb_mult_unit.sv - directed self-checking bench for mult_unit
module tb_mult_unit;

  logic        clk;
  logic        reset_n;
  logic        start;
  logic        is_signed;
  logic [31:0] op_a;
  logic [31:0] op_b;
  logic        hi_we;
  logic        lo_we;
  logic [31:0] wdata;
  logic        busy;
  logic        done;
  logic [31:0] hi;
  logic [31:0] lo;

  int total = 0;
  int bad   = 0;
  int n;
  int bcnt;
  int n2;

  mult_unit #(.WIDTH(32)) dut (
    .clk       (clk),
    .reset_n   (reset_n),
    .start     (start),
    .is_signed (is_signed),
    .op_a      (op_a),
    .op_b      (op_b),
    .hi_we     (hi_we),
    .lo_we     (lo_we),
    .wdata     (wdata),
    .busy      (busy),
    .done      (done),
    .hi        (hi),
    .lo        (lo)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=0x%08h expected=0x%08h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic drive_start(input logic [31:0] a, input logic [31:0] b, input logic s);
    start     = 1'b1;
    op_a      = a;
    op_b      = b;
    is_signed = s;
  endtask

  // Counts edges until done is seen (bounded) and how many samples had busy high.
  task automatic wait_done(output int edges, output int busy_cycles);
    edges       = 0;
    busy_cycles = 0;
    while (edges < 60) begin
      tick();
      edges++;
      if (done) break;
      if (busy) busy_cycles++;
    end
  endtask

  task automatic run(input string tag, input logic [31:0] a, input logic [31:0] b, input logic s,
                     input logic [31:0] exp_hi, input logic [31:0] exp_lo);
    int e;
    int bc;
    drive_start(a, b, s);
    tick();
    start = 1'b0;
    wait_done(e, bc);
    chk({tag, "_latency"}, 32'(e), 32'd33);
    chk({tag, "_hi"}, hi, exp_hi);
    chk({tag, "_lo"}, lo, exp_lo);
  endtask

  initial begin
    reset_n   = 1'b0;
    start     = 1'b0;
    is_signed = 1'b0;
    op_a      = '0;
    op_b      = '0;
    hi_we     = 1'b0;
    lo_we     = 1'b0;
    wdata     = '0;
    tick();
    tick();
    chk("rst_hi", hi, 32'h0);
    chk("rst_lo", lo, 32'h0);
    chk("rst_busy", 32'(busy), 32'd0);
    chk("rst_done", 32'(done), 32'd0);
    reset_n = 1'b1;
    tick();

    // unsigned max with latency and busy length
    drive_start(32'hFFFF_FFFF, 32'hFFFF_FFFF, 1'b0);
    tick();
    start = 1'b0;
    chk("umax_busy_e0", 32'(busy), 32'd1);
    wait_done(n, bcnt);
    chk("umax_latency", 32'(n), 32'd33);
    chk("umax_busy_cycles", 32'(bcnt + 1), 32'd33);
    chk("umax_busy_done", 32'(busy), 32'd0);
    chk("umax_hi", hi, 32'hFFFF_FFFE);
    chk("umax_lo", lo, 32'h0000_0001);
    tick();
    chk("umax_done_pulse", 32'(done), 32'd0);

    run("neg3x7", 32'hFFFF_FFFD, 32'd7, 1'b1, 32'hFFFF_FFFF, 32'hFFFF_FFEB);
    run("min_sq", 32'h8000_0000, 32'h8000_0000, 1'b1, 32'h4000_0000, 32'h0);
    run("neg_zero", 32'hFFFF_FFFF, 32'h0, 1'b1, 32'h0, 32'h0);
    run("u_min_x2", 32'h8000_0000, 32'd2, 1'b0, 32'h1, 32'h0);

    // busy protection: second start and mthi during CALC are ignored
    drive_start(32'd3, 32'd4, 1'b0);
    tick();
    start = 1'b0;
    for (int k = 1; k <= 9; k++) tick();
    drive_start(32'd5, 32'd5, 1'b0);
    hi_we = 1'b1;
    wdata = 32'h0000_DEAD;
    tick();
    start = 1'b0;
    hi_we = 1'b0;
    chk("calc_hi_hold", hi, 32'h1);
    chk("calc_busy", 32'(busy), 32'd1);
    wait_done(n, bcnt);
    chk("prot_latency", 32'(n + 10), 32'd33);
    chk("prot_hi", hi, 32'h0);
    chk("prot_lo", lo, 32'd12);
    tick();
    chk("prot_no_restart", 32'(busy), 32'd0);

    hi_we = 1'b1;
    wdata = 32'h0000_DEAD;
    tick();
    hi_we = 1'b0;
    chk("mthi_idle_hi", hi, 32'h0000_DEAD);
    chk("mthi_idle_lo", lo, 32'd12);
    lo_we = 1'b1;
    wdata = 32'h0000_BEEF;
    tick();
    lo_we = 1'b0;
    chk("mtlo_idle_lo", lo, 32'h0000_BEEF);

    // reset in the middle of a multiply
    drive_start(32'd9, 32'd9, 1'b0);
    tick();
    start = 1'b0;
    for (int k = 1; k <= 15; k++) tick();
    reset_n = 1'b0;
    #1;
    chk("mid_rst_hi", hi, 32'h0);
    chk("mid_rst_lo", lo, 32'h0);
    chk("mid_rst_busy", 32'(busy), 32'd0);
    chk("mid_rst_done", 32'(done), 32'd0);
    tick();
    reset_n = 1'b1;
    tick();
    run("post_rst_6x7", 32'd6, 32'd7, 1'b0, 32'h0, 32'd42);

    // back-to-back: restart in the done cycle
    drive_start(32'd2, 32'd3, 1'b0);
    tick();
    start = 1'b0;
    wait_done(n, bcnt);
    chk("b2b_first_lo", lo, 32'd6);
    drive_start(32'd4, 32'd5, 1'b0);
    tick();
    start = 1'b0;
    chk("b2b_accept_busy", 32'(busy), 32'd1);
    wait_done(n2, bcnt);
    chk("b2b_latency", 32'(n2), 32'd33);
    chk("b2b_second_lo", lo, 32'd20);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
